// File: rtl/lifo_pkg.sv
`default_nettype none
// ============================================================
// Module : lifo_pkg
// Desc   : Shared types and helpers for the lifo_stack block.
// Rev    : 1.0
// ============================================================
package lifo_pkg;

  typedef enum logic [1:0] {
    OP_IDLE = 2'd0,
    OP_PUSH = 2'd1,
    OP_POP  = 2'd2,
    OP_SWAP = 2'd3
  } op_e;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Clear dominates; a cleared cycle performs no stack operation.
  function automatic op_e decode_op(input logic clr, input logic push, input logic pop);
    if (clr)              return OP_IDLE;
    else if (push && pop) return OP_SWAP;
    else if (push)        return OP_PUSH;
    else if (pop)         return OP_POP;
    else                  return OP_IDLE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lifo_mem.sv
`default_nettype none
// ============================================================
// Module : lifo_mem
// Desc   : WIDTH x DEPTH register array, 1 sync write, 1 async read.
// Rev    : 1.0
// ============================================================
module lifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Storage is deliberately not reset; validity is tracked by the count.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/lifo_stack.sv
`default_nettype none
// ============================================================
// Module : lifo_stack
// Desc   : Parametrised LIFO with peek, swap, flags and sync clear.
// Rev    : 1.0
// ============================================================
module lifo_stack
  import lifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AF_MARGIN = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr_i,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic [WIDTH-1:0]        wdata_i,
  output logic [WIDTH-1:0]        rdata_o,
  output logic                    rvalid_o,
  output logic [WIDTH-1:0]        top_o,
  output logic [cnt_w(DEPTH)-1:0] count_o,
  output logic                    empty_o,
  output logic                    full_o,
  output logic                    almost_full_o,
  output logic                    ovf_o,
  output logic                    udf_o
);

  localparam int CW = cnt_w(DEPTH);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  generate
    if (DEPTH < 2 || AF_MARGIN < 0 || AF_MARGIN >= DEPTH || WIDTH < 1) begin : g_param_check
      $error("lifo_stack: illegal parameters (WIDTH>=1, DEPTH>=2, 0<=AF_MARGIN<DEPTH)");
    end
  endgenerate

  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;

  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [WIDTH-1:0] mem_top;
  logic [CW-1:0]    top_full_idx;
  logic [AW-1:0]    top_idx;
  logic             is_empty, is_full;
  op_e              op;

  assign is_empty     = (count_q == '0);
  assign is_full      = (count_q == CW'(DEPTH));
  assign top_full_idx = count_q - CW'(1);
  assign top_idx      = top_full_idx[AW-1:0];

  lifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (wdata_i),
    .raddr_i (top_idx),
    .rdata_o (mem_top)
  );

  always_comb begin
    op        = decode_op(clr_i, push_i, pop_i);
    count_d   = count_q;
    rdata_d   = rdata_q;
    rvalid_d  = 1'b0;
    ovf_d     = ovf_q;
    udf_d     = udf_q;
    mem_we    = 1'b0;
    mem_waddr = count_q[AW-1:0];
    if (clr_i) begin
      count_d = '0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
    end else begin
      case (op)
        OP_PUSH: begin
          if (is_full) begin
            ovf_d = 1'b1;
          end else begin
            mem_we  = 1'b1;
            count_d = count_q + CW'(1);
          end
        end
        OP_POP: begin
          if (is_empty) begin
            udf_d = 1'b1;
          end else begin
            rdata_d  = mem_top;
            rvalid_d = 1'b1;
            count_d  = top_full_idx;
          end
        end
        OP_SWAP: begin
          rvalid_d = 1'b1;
          // An empty swap is a pure pass-through; nothing is stored.
          if (is_empty) begin
            rdata_d = wdata_i;
          end else begin
            rdata_d   = mem_top;
            mem_we    = 1'b1;
            mem_waddr = top_idx;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  assign rdata_o       = rdata_q;
  assign rvalid_o      = rvalid_q;
  assign top_o         = is_empty ? '0 : mem_top;
  assign count_o       = count_q;
  assign empty_o       = is_empty;
  assign full_o        = is_full;
  assign almost_full_o = (count_q >= CW'(DEPTH - AF_MARGIN));
  assign ovf_o         = ovf_q;
  assign udf_o         = udf_q;

endmodule
`default_nettype wire

// File: tb/tb_lifo_stack.sv
`default_nettype none
// ============================================================
// Module : tb_lifo_stack
// Desc   : Directed + random bench for lifo_stack against a queue model.
// Rev    : 1.0
// ============================================================
module tb_lifo_stack;

  localparam int WIDTH     = 8;
  localparam int DEPTH     = 4;
  localparam int AF_MARGIN = 1;
  localparam int CW        = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clr_i = 1'b0;
  logic             push_i = 1'b0;
  logic             pop_i = 1'b0;
  logic [WIDTH-1:0] wdata_i = '0;
  logic [WIDTH-1:0] rdata_o;
  logic             rvalid_o;
  logic [WIDTH-1:0] top_o;
  logic [CW-1:0]    count_o;
  logic             empty_o, full_o, almost_full_o, ovf_o, udf_o;

  always #5 clk = ~clk;

  lifo_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_MARGIN(AF_MARGIN)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clr_i         (clr_i),
    .push_i        (push_i),
    .pop_i         (pop_i),
    .wdata_i       (wdata_i),
    .rdata_o       (rdata_o),
    .rvalid_o      (rvalid_o),
    .top_o         (top_o),
    .count_o       (count_o),
    .empty_o       (empty_o),
    .full_o        (full_o),
    .almost_full_o (almost_full_o),
    .ovf_o         (ovf_o),
    .udf_o         (udf_o)
  );

  // Reference model: the stack is a queue whose back is the top.
  logic [WIDTH-1:0] m_stack[$];
  logic [WIDTH-1:0] m_rdata;
  logic             m_rvalid, m_ovf, m_udf;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_stack.delete();
    m_rdata  = '0;
    m_rvalid = 1'b0;
    m_ovf    = 1'b0;
    m_udf    = 1'b0;
  endtask

  task automatic model_step(input logic c, input logic pu, input logic po, input logic [WIDTH-1:0] wd);
    m_rvalid = 1'b0;
    if (c) begin
      m_stack.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else if (pu && po) begin
      m_rvalid = 1'b1;
      if (m_stack.size() == 0) begin
        m_rdata = wd;
      end else begin
        m_rdata = m_stack[m_stack.size()-1];
        m_stack[m_stack.size()-1] = wd;
      end
    end else if (pu) begin
      if (m_stack.size() == DEPTH) m_ovf = 1'b1;
      else m_stack.push_back(wd);
    end else if (po) begin
      if (m_stack.size() == 0) begin
        m_udf = 1'b1;
      end else begin
        m_rdata  = m_stack.pop_back();
        m_rvalid = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    logic [WIDTH-1:0] exp_top;
    int sz;
    sz      = m_stack.size();
    exp_top = (sz == 0) ? '0 : m_stack[sz-1];
    check("count",  32'(count_o),       32'(sz));
    check("empty",  32'(empty_o),       32'(sz == 0));
    check("full",   32'(full_o),        32'(sz == DEPTH));
    check("afull",  32'(almost_full_o), 32'(sz >= DEPTH - AF_MARGIN));
    check("ovf",    32'(ovf_o),         32'(m_ovf));
    check("udf",    32'(udf_o),         32'(m_udf));
    check("rvalid", 32'(rvalid_o),      32'(m_rvalid));
    check("rdata",  32'(rdata_o),       32'(m_rdata));
    check("top",    32'(top_o),         32'(exp_top));
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are checked there too.
  task automatic step(input logic c, input logic pu, input logic po, input logic [WIDTH-1:0] wd);
    clr_i   = c;
    push_i  = pu;
    pop_i   = po;
    wdata_i = wd;
    @(posedge clk);
    model_step(c, pu, po, wd);
    #1;
    clr_i  = 1'b0;
    push_i = 1'b0;
    pop_i  = 1'b0;
    check_all();
  endtask

  initial begin
    logic [WIDTH-1:0] pop_exp [4];
    pop_exp[0] = 8'h44; pop_exp[1] = 8'h33; pop_exp[2] = 8'h22; pop_exp[3] = 8'h11;

    model_reset();
    #1;
    check_all();
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Fill to almost-full
    step(0, 1, 0, 8'h11);
    step(0, 1, 0, 8'h22);
    step(0, 1, 0, 8'h33);
    check("tp_af",   32'(almost_full_o), 32'd1);
    check("tp_top3", 32'(top_o),         32'h33);

    // Fill, then overflow
    step(0, 1, 0, 8'h44);
    step(0, 1, 0, 8'h55);
    check("tp_full", 32'(full_o), 32'd1);
    check("tp_ovf",  32'(ovf_o),  32'd1);
    check("tp_top4", 32'(top_o),  32'h44);

    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 8'h00);
      check("tp_pop", 32'(rdata_o), 32'(pop_exp[i]));
    end
    check("tp_empty", 32'(empty_o), 32'd1);

    // Underflow keeps rdata, then clear drops the sticky flags
    step(0, 0, 1, 8'h00);
    check("tp_udf_rdata", 32'(rdata_o), 32'h11);
    step(1, 0, 0, 8'h00);
    check("tp_clr_ovf", 32'(ovf_o), 32'd0);

    // Swap on non-empty and empty stacks
    step(0, 1, 0, 8'hA0);
    step(0, 1, 1, 8'hB0);
    check("tp_swap_rd",  32'(rdata_o), 32'hA0);
    check("tp_swap_top", 32'(top_o),   32'hB0);
    step(0, 0, 1, 8'h00);
    step(0, 1, 1, 8'hC0);
    check("tp_swap_pass", 32'(rdata_o), 32'hC0);

    // Clear has priority over push/pop
    step(0, 1, 0, 8'h5A);
    step(1, 1, 1, 8'h77);

    // Random traffic: push-heavy then pop-heavy phases
    for (int i = 0; i < 600; i++) begin
      int  r;
      logic c, pu, po;
      r  = int'($urandom_range(0, 99));
      c  = (r < 2);
      pu = ($urandom_range(0, 99) < ((i < 300) ? 60 : 40));
      po = ($urandom_range(0, 99) < ((i < 300) ? 40 : 60));
      step(c, pu, po, WIDTH'($urandom));
    end

    // Asynchronous reset between edges
    step(0, 1, 0, 8'h01);
    step(0, 1, 0, 8'h02);
    step(0, 1, 0, 8'h03);
    step(0, 0, 1, 8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_count",  32'(count_o),  32'd0);
    check("arst_empty",  32'(empty_o),  32'd1);
    check("arst_rvalid", 32'(rvalid_o), 32'd0);
    check("arst_rdata",  32'(rdata_o),  32'd0);
    push_i  = 1'b1;
    wdata_i = 8'h99;
    @(posedge clk); #1;
    push_i = 1'b0;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    step(0, 0, 1, 8'h00);
    step(0, 1, 0, 8'hE1);
    step(0, 0, 0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/lifo_stack.md
Name: lifo_stack

Overview:
- Parametrised single-clock LIFO (hardware stack); the next generation of the team's fixed lifo block.
- Adds configurable width and depth, a combinational top-of-stack peek and a registered pop path.
- Adds simultaneous push+pop (swap), an almost-full threshold, an occupancy count, sticky overflow/underflow flags and a synchronous clear.
- Sits between a producer and consumer in the datapath, e.g. for return-address or context storage.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 16, number of entries (>=2).
- AF_MARGIN, 2, almost_full_o asserts when count_o >= DEPTH-AF_MARGIN (0 <= AF_MARGIN < DEPTH).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr_i  in  1  synchronous clear.
- push_i  in  1  push request.
- pop_i  in  1  pop request.
- wdata_i  in  WIDTH  data to push.
- rdata_o  out  WIDTH  popped word, registered.
- rvalid_o  out  1  rdata_o updated by a successful pop this cycle; 1-cycle pulse.
- top_o  out  WIDTH  combinational peek of the current top entry; 0 when empty.
- count_o  out  $clog2(DEPTH+1)  number of stored entries.
- empty_o  out  1  count_o == 0.
- full_o  out  1  count_o == DEPTH.
- almost_full_o  out  1  count_o >= DEPTH-AF_MARGIN.
- ovf_o  out  1  sticky: push was dropped because the stack was full.
- udf_o  out  1  sticky: pop was issued on an empty stack.

Behaviour:
- Reset (rst_n=0, asynchronous): count_o=0, rdata_o=0, rvalid_o=0, ovf_o=0, udf_o=0. Hence empty_o=1, full_o=0, almost_full_o=(AF_MARGIN>=DEPTH ? 1 : 0), which is 0 for legal parameters. Storage array is not reset.
- Reset mid-operation discards all contents immediately; a push/pop in the same cycle as reset has no effect.
- Priority per cycle: clr_i > swap (push&pop) > push > pop.
- Clear (clr_i=1): count_o=0, rvalid_o=0, ovf_o=0, udf_o=0; rdata_o holds; push/pop ignored.
- Push only, not full: mem[count]<=wdata_i; count+1.
- Push only, full: word dropped; count unchanged; ovf_o<=1.
- Pop only, not empty: rdata_o<=mem[count-1]; rvalid_o<=1; count-1. Latency: data appears on rdata_o the cycle after pop_i is sampled.
- Pop only, empty: count, rdata_o unchanged; rvalid_o<=0; udf_o<=1.
- Swap, not empty (including full): rdata_o<=old mem[count-1]; mem[count-1]<=wdata_i; rvalid_o<=1; count unchanged; no ovf.
- Swap, empty: pass-through; rdata_o<=wdata_i; rvalid_o<=1; count stays 0; no udf.
- Idle cycle: rvalid_o<=0; everything else holds.
- top_o reflects the write of cycle N from cycle N+1; it is never read-during-write forwarded.
- ovf_o/udf_o clear only on reset or clr_i.
- Pointer: the top index is count_o-1; there is no wrap-around, and count saturates at 0 and DEPTH via the rules above.
- Parameter violations (DEPTH<2, AF_MARGIN>=DEPTH) are caught by an elaboration-time $error.

Decomposition:
- Package lifo_pkg:
  - op_e enum {OP_IDLE, OP_PUSH, OP_POP, OP_SWAP}, decoded from clr/push/pop.
  - cnt_w(depth) function returning $clog2(depth+1).
- Sub-module lifo_mem: WIDTH x DEPTH register array with one synchronous write port and one asynchronous read port (index count-1). The top level keeps count, flags and the rdata register.

Test Plan:
- WIDTH=8, DEPTH=4, AF_MARGIN=1. Reset, then push 0x11,0x22,0x33 -> count_o=3, almost_full_o=1, full_o=0, top_o=0x33.
- Push 0x44, then push 0x55 -> full_o=1, count_o=4, ovf_o=1, top_o=0x44; 0x55 lost.
- Pop x4 on consecutive cycles -> rdata_o 0x44,0x33,0x22,0x11, each one cycle after its pop, rvalid_o high 4 cycles; then empty_o=1.
- Pop on empty -> udf_o=1, rvalid_o=0, rdata_o stays 0x11. Then clr_i for 1 cycle -> ovf_o=0, udf_o=0.
- Push 0xA0; then swap with 0xB0 -> rdata_o=0xA0, rvalid_o=1, count_o=1, top_o=0xB0. Swap on empty with 0xC0 -> rdata_o=0xC0, count_o=0.
- Push 0x01,0x02, assert rst_n=0 between clock edges -> count_o=0, empty_o=1, rvalid_o=0 immediately, without waiting for a clock edge.
